imem_loader: RTL

Boot-time program loader upstream of the single-cycle RISC-V core. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes those words into instruction memory through a one-cycle write port, then releases the core from reset once the frame checksum verifies. On a malformed frame it parks in an error state with the core held in reset.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// ImemLoader (module imem_loader)
//
// Boot-time program loader placed in front of the single-cycle RISC-V core.
// It accepts a framed byte stream, assembles little-endian 32-bit instruction
// words and writes them into instruction memory through a one-cycle write
// port. Once the trailing XOR checksum matches, the core is released from
// reset. A malformed frame parks the loader in an error state with the core
// still held in reset.
//
// Frame: LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes, 1 checksum
// byte (XOR of all data bytes, length bytes excluded).
//
// Ports
//   clk_i            single clock, everything changes on posedge
//   rst_i            synchronous active-high reset
//   byte_valid_i     source presents byte_data_i this cycle
//   byte_data_i      frame byte
//   byte_ready_o     loader can take a byte (decoded from state only)
//   imem_we_o        one-cycle instruction-memory write strobe
//   imem_addr_o      byte address of the write (multiple of 4)
//   imem_wdata_o     instruction word being written
//   core_rst_o       reset to the core, high until a valid load completes
//   done_o           load succeeded, core running
//   error_o          frame rejected
//   words_loaded_o   number of words written in the current frame
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int MAX_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic        error_o,
    output logic [5:0]  words_loaded_o
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [7:0]  lenLo_q;
    logic [5:0]  lastIdx_q;
    logic [1:0]  byteIdx_q;
    logic [5:0]  wordIdx_q;
    logic [7:0]  csum_q;
    logic [23:0] asm_q;
    logic        imemWe_q;
    logic [31:0] imemAddr_q;
    logic [31:0] imemWdata_q;
    logic        coreRst_q;
    logic        done_q;
    logic        error_q;
    logic [5:0]  wordsLoaded_q;

    logic        xfer;
    logic [15:0] lenFull_d;
    logic        lenBad;
    logic [7:0]  csum_d;
    logic [5:0]  wordIdx_d;

    // Ready depends on the registered state alone, so there is never a
    // combinational path from byte_valid_i back to byte_ready_o.
    assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);

    assign xfer = byte_valid_i & byte_ready_o;

    // The full 16-bit count is checked, so any nonzero LEN_HI is rejected
    // for memories of 255 words or fewer.
    assign lenFull_d = {byte_data_i, lenLo_q};
    assign lenBad    = (lenFull_d == 16'd0) || (lenFull_d > 16'(MAX_WORDS));
    assign csum_d    = csum_q ^ byte_data_i;
    assign wordIdx_d = wordIdx_q + 6'd1;

    // Whole loader FSM. Every output is a register; the write strobe is
    // cleared each cycle and only re-asserted on the byte that completes a
    // word, which gives the one-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_LEN_LO;
            lenLo_q       <= 8'd0;
            lastIdx_q     <= 6'd0;
            byteIdx_q     <= 2'd0;
            wordIdx_q     <= 6'd0;
            csum_q        <= 8'd0;
            asm_q         <= 24'd0;
            imemWe_q      <= 1'b0;
            imemAddr_q    <= 32'd0;
            imemWdata_q   <= 32'd0;
            coreRst_q     <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            wordsLoaded_q <= 6'd0;
        end else begin
            imemWe_q <= 1'b0;
            if (xfer) begin
                case (state_q)
                    S_LEN_LO: begin
                        lenLo_q <= byte_data_i;
                        state_q <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if (lenBad) begin
                            error_q <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            lastIdx_q <= lenFull_d[5:0] - 6'd1;
                            byteIdx_q <= 2'd0;
                            wordIdx_q <= 6'd0;
                            csum_q    <= 8'd0;
                            state_q   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum_q    <= csum_d;
                        byteIdx_q <= byteIdx_q + 2'd1;
                        case (byteIdx_q)
                            2'd0: asm_q[7:0]   <= byte_data_i;
                            2'd1: asm_q[15:8]  <= byte_data_i;
                            2'd2: asm_q[23:16] <= byte_data_i;
                            default: begin
                                imemWdata_q   <= {byte_data_i, asm_q};
                                imemAddr_q    <= {24'd0, wordIdx_q, 2'b00};
                                imemWe_q      <= 1'b1;
                                wordIdx_q     <= wordIdx_d;
                                wordsLoaded_q <= wordsLoaded_q + 6'd1;
                                if (wordIdx_q == lastIdx_q) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (byte_data_i == csum_q) begin
                            coreRst_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign imem_we_o      = imemWe_q;
    assign imem_addr_o    = imemAddr_q;
    assign imem_wdata_o   = imemWdata_q;
    assign core_rst_o     = coreRst_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = wordsLoaded_q;

endmodule
